// File: rtl/mmio_led_pkg.sv
// Shared constants for the memory-mapped LED controller: register word addresses
// and the per-channel output mode encodings.
package mmio_led_pkg;

    localparam int unsigned ADDR_DATA      = 0;
    localparam int unsigned ADDR_MODE      = 1;
    localparam int unsigned ADDR_PRESC     = 2;
    localparam int unsigned ADDR_STATUS    = 3;
    localparam int unsigned ADDR_DUTY_BASE = 4;

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_BLINK     = 2'b01,
        MODE_PWM       = 2'b10,
        MODE_BLINK_PWM = 2'b11
    } led_mode_e;

endpackage

// File: rtl/mmio_led_channel.sv
// One LED output channel: selects direct, blink, PWM or blinking-PWM gating of its
// data bit and registers the result.
module mmio_led_channel
    import mmio_led_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_bit,
    input  led_mode_e           mode,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                blink_phase,
    output logic                led
);

    logic pwm_on;
    logic led_next;

    assign pwm_on = (pwm_cnt < duty);

    always_comb begin
        led_next = 1'b0;
        case (mode)
            MODE_DIRECT:    led_next = data_bit;
            MODE_BLINK:     led_next = data_bit & blink_phase;
            MODE_PWM:       led_next = data_bit & pwm_on;
            MODE_BLINK_PWM: led_next = data_bit & pwm_on & blink_phase;
            default:        led_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 1'b0;
        end else begin
            led <= led_next;
        end
    end

endmodule

// File: rtl/mmio_led_ctrl.sv
// Memory-mapped LED/GPIO output peripheral: register file, shared blink prescaler and
// free-running PWM counter, plus NUM_CH output channels.
module mmio_led_ctrl
    import mmio_led_pkg::*;
#(
    parameter int unsigned            BUS_WIDTH     = 32,
    parameter int unsigned            NUM_CH        = 8,
    parameter int unsigned            ADDR_WIDTH    = 5,
    parameter int unsigned            PWM_BITS      = 8,
    parameter int unsigned            PRESC_WIDTH   = 24,
    parameter logic [PRESC_WIDTH-1:0] BLINK_DEFAULT = PRESC_WIDTH'(12_499_999)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BUS_WIDTH-1:0]  wdata,
    input  logic                  we,
    input  logic                  re,
    output logic [BUS_WIDTH-1:0]  rdata,
    output logic                  rvalid,
    output logic [NUM_CH-1:0]     led
);

    logic [NUM_CH-1:0]      data;
    logic [2*NUM_CH-1:0]    mode;
    logic [PRESC_WIDTH-1:0] presc;
    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic                   blink_phase;
    logic [PWM_BITS-1:0]    pwm_cnt;
    logic [PWM_BITS-1:0]    duty [NUM_CH];
    logic [BUS_WIDTH-1:0]   rd_val;

    logic              sel_data;
    logic              sel_mode;
    logic              sel_presc;
    logic              sel_status;
    logic [NUM_CH-1:0] sel_duty;

    assign sel_data   = (addr == ADDR_WIDTH'(ADDR_DATA));
    assign sel_mode   = (addr == ADDR_WIDTH'(ADDR_MODE));
    assign sel_presc  = (addr == ADDR_WIDTH'(ADDR_PRESC));
    assign sel_status = (addr == ADDR_WIDTH'(ADDR_STATUS));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sel
        assign sel_duty[i] = (addr == ADDR_WIDTH'(ADDR_DUTY_BASE + i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            mode  <= '0;
            presc <= BLINK_DEFAULT;
            for (int i = 0; i < NUM_CH; i++) begin
                duty[i] <= '0;
            end
        end else if (we) begin
            if (sel_data)  data  <= wdata[NUM_CH-1:0];
            if (sel_mode)  mode  <= wdata[2*NUM_CH-1:0];
            if (sel_presc) presc <= wdata[PRESC_WIDTH-1:0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel_duty[i]) duty[i] <= wdata[PWM_BITS-1:0];
            end
        end
    end

    // A PRESC write restarts the blink period from phase 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt   <= '0;
            blink_phase <= 1'b0;
            pwm_cnt     <= '0;
        end else begin
            if (we && sel_presc) begin
                presc_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (presc_cnt == presc) begin
                presc_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    always_comb begin
        rd_val = '0;
        if (sel_data)  rd_val[NUM_CH-1:0]      = data;
        if (sel_mode)  rd_val[2*NUM_CH-1:0]    = mode;
        if (sel_presc) rd_val[PRESC_WIDTH-1:0] = presc;
        if (sel_status) begin
            rd_val[0]          = blink_phase;
            rd_val[PWM_BITS:1] = pwm_cnt;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_duty[i]) rd_val[PWM_BITS-1:0] = duty[i];
        end
    end

    // Read data is sampled before any same-edge write lands, so it returns the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) rdata <= rd_val;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_mode_e ch_mode;
        assign ch_mode = led_mode_e'(mode[2*i +: 2]);

        mmio_led_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .data_bit   (data[i]),
            .mode       (ch_mode),
            .duty       (duty[i]),
            .pwm_cnt    (pwm_cnt),
            .blink_phase(blink_phase),
            .led        (led[i])
        );
    end

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// Bench for mmio_led_ctrl: directed bus traffic, an arithmetic reference model checked
// every cycle, and literal expectations for reset, timing and PWM/blink boundaries.
module tb_mmio_led_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        rvalid;
    logic [7:0]  led;

    int total = 0;
    int bad   = 0;

    mmio_led_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .re    (re),
        .rdata (rdata),
        .rvalid(rvalid),
        .led   (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents plus elapsed-cycle counts; phase and PWM position
    // are derived by division/modulo rather than by stepping counters.
    logic [7:0]  m_data;
    logic [15:0] m_mode;
    logic [23:0] m_presc;
    logic [7:0]  m_duty [8];
    longint      since_presc;
    longint      since_rst;
    logic        model_valid = 1'b0;
    logic [31:0] exp_rdata;
    logic        exp_rvalid;
    logic [7:0]  exp_led;

    function automatic logic m_phase();
        return 1'((since_presc / (longint'(m_presc) + 1)) % 2);
    endfunction

    function automatic logic [7:0] m_pwm();
        return 8'(since_rst % 256);
    endfunction

    function automatic logic [7:0] model_led();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            logic [1:0] md;
            md   = m_mode[2*i +: 2];
            v[i] = m_data[i] & (md[0] ? m_phase() : 1'b1) & (md[1] ? (m_pwm() < m_duty[i]) : 1'b1);
        end
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            5'd0: v = 32'(m_data);
            5'd1: v = 32'(m_mode);
            5'd2: v = 32'(m_presc);
            5'd3: v = {23'b0, m_pwm(), m_phase()};
            default: if (a >= 5'd4 && a < 5'd12) v = 32'(m_duty[a - 5'd4]);
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst) begin
            m_data      = '0;
            m_mode      = '0;
            m_presc     = 24'd12_499_999;
            for (int i = 0; i < 8; i++) m_duty[i] = '0;
            since_presc = 0;
            since_rst   = 0;
            exp_rdata   = '0;
            exp_rvalid  = 1'b0;
            exp_led     = '0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            exp_led    = model_led();
            exp_rvalid = re;
            if (re) exp_rdata = model_read(addr);
            if (we) begin
                case (addr)
                    5'd0: m_data  = wdata[7:0];
                    5'd1: m_mode  = wdata[15:0];
                    5'd2: m_presc = wdata[23:0];
                    default: if (addr >= 5'd4 && addr < 5'd12) m_duty[addr - 5'd4] = wdata[7:0];
                endcase
            end
            if (we && addr == 5'd2) since_presc = 0;
            else since_presc++;
            since_rst++;
        end
        if (model_valid) begin
            check("model_led", 32'(led), 32'(exp_led));
            check("model_rvalid", 32'(rvalid), 32'(exp_rvalid));
            check("model_rdata", rdata, exp_rdata);
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        re = 1'b1; addr = a;
        @(negedge clk);
        re = 1'b0;
        d = rdata;
        check("rd_rvalid", 32'(rvalid), 32'd1);
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (led[0]) hi++;
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [11:0] blink_pat;
        int          hi;

        blink_pat = 12'b0000_1111_0000;
        rst = 1'b1; we = 1'b1; re = 1'b0; addr = 5'd0; wdata = 32'hFF;
        repeat (2) @(negedge clk);
        check("reset_led", 32'(led), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_rvalid", 32'(rvalid), 32'h0);
        rst = 1'b0; we = 1'b0; wdata = '0;
        rd(5'd2, r);
        check("presc_default", r, 32'd12_499_999);

        // Direct mode and write-to-LED latency.
        wr(5'd0, 32'hA5);
        check("led_not_same_edge", 32'(led), 32'h0);
        @(negedge clk);
        check("led_direct", 32'(led), 32'hA5);
        rd(5'd0, r);
        check("read_data", r, 32'hA5);
        @(negedge clk);
        check("rvalid_one_cycle", 32'(rvalid), 32'h0);

        // Blink with PRESC=3, then a mid-phase PRESC rewrite.
        wr(5'd1, 32'h1);
        wr(5'd0, 32'h1);
        wr(5'd2, 32'd3);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            check("blink_pattern", 32'(led[0]), 32'(blink_pat[j]));
        end
        repeat (2) @(negedge clk);
        wr(5'd2, 32'd3);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("blink_restart", 32'(led[0]), 32'(blink_pat[j]));
        end

        // PWM duty boundaries.
        wr(5'd1, 32'h2);
        wr(5'd4, 32'd0);
        @(negedge clk);
        count_high(512, hi);
        check("pwm_duty0", 32'(hi), 32'd0);
        wr(5'd4, 32'd64);
        @(negedge clk);
        count_high(256, hi);
        check("pwm_duty64", 32'(hi), 32'd64);
        wr(5'd4, 32'd255);
        @(negedge clk);
        count_high(256, hi);
        check("pwm_duty255", 32'(hi), 32'd255);

        // Same-cycle write and read to DATA returns the old value.
        wr(5'd0, 32'h0F);
        @(negedge clk);
        we = 1'b1; re = 1'b1; addr = 5'd0; wdata = 32'hF0;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        check("rw_same_cycle", rdata, 32'h0F);
        rd(5'd0, r);
        check("rw_new_value", r, 32'hF0);

        // Writes to STATUS and an unmapped address are ignored.
        wr(5'd3, 32'hFFFF_FFFF);
        wr(5'd31, 32'hFFFF_FFFF);
        rd(5'd31, r);
        check("unmapped_read", r, 32'h0);
        rd(5'd0, r);
        check("data_untouched", r, 32'hF0);
        rd(5'd1, r);
        check("mode_untouched", r, 32'h2);
        rd(5'd2, r);
        check("presc_untouched", r, 32'd3);

        // Blinking PWM: dark in phase 0, half duty in phase 1.
        wr(5'd4, 32'd128);
        wr(5'd0, 32'h1);
        wr(5'd1, 32'h3);
        wr(5'd2, 32'd255);
        count_high(256, hi);
        check("bpwm_phase0", 32'(hi), 32'd0);
        count_high(256, hi);
        check("bpwm_phase1", 32'(hi), 32'd128);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_led_ctrl.md
Name: mmio_led_ctrl

Overview:
- Parametrised memory-mapped LED/GPIO output peripheral.
- Replaces the direct bus-bit-to-LED wiring at the board top level.
- Sits on the processor's memory-mapped IO bus and drives NUM_CH board outputs.
- Each channel runs in one of four modes: direct, blink, PWM or blinking PWM. Blink timing and PWM duty are software-controlled.

Parameters:
- BUS_WIDTH, 32, data bus width.
- NUM_CH, 8, number of output channels; legal range 1..16, so MODE fits in 32 bits.
- ADDR_WIDTH, 5, word-address width; must satisfy 4+NUM_CH <= 2^ADDR_WIDTH.
- PWM_BITS, 8, PWM counter and duty width.
- PRESC_WIDTH, 24, blink prescaler width.
- BLINK_DEFAULT, 24'd12_499_999, reset value of PRESC.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- addr  in  ADDR_WIDTH  word address.
- wdata  in  BUS_WIDTH  write data.
- we  in  1  write strobe, single cycle.
- re  in  1  read strobe, single cycle.
- rdata  out  BUS_WIDTH  registered read data.
- rvalid  out  1  high one cycle after an accepted read.
- led  out  NUM_CH  registered channel outputs.

Behaviour:
- Clocking and reset:
  - One clock domain (clk); reset is synchronous and active-high (rst).
  - When rst is sampled high, all registers reset: DATA=0, MODE=0, DUTY[i]=0, PRESC=BLINK_DEFAULT, presc_cnt=0, blink_phase=0, pwm_cnt=0, rdata=0, rvalid=0, led=0.
  - Reset mid-operation overrides any concurrent we/re.
- Register map (word addresses):
  - 0 DATA [NUM_CH-1:0] R/W.
  - 1 MODE, 2 bits per channel, channel i at [2i+1:2i], R/W.
  - 2 PRESC [PRESC_WIDTH-1:0] R/W.
  - 3 STATUS, read-only: [0]=blink_phase, [PWM_BITS:1]=pwm_cnt.
  - 4+i DUTY[i] [PWM_BITS-1:0] R/W.
  - Unused upper bits read 0 and are ignored on write.
  - Unmapped addresses read 0; writes to them, and to STATUS, are ignored.
- Write timing:
  - we sampled at edge k updates the register at edge k.
  - led reflects the new value at edge k+1.
- Read timing:
  - re sampled at edge k gives rdata and rvalid=1 at edge k.
  - rvalid is high for exactly one cycle per re.
  - When re is low, rdata holds its last value.
  - Simultaneous we and re to the same address: rdata returns the pre-write value.
- Blink prescaler:
  - presc_cnt increments every cycle.
  - When presc_cnt==PRESC: presc_cnt<=0 and blink_phase toggles.
  - Blink half-period is PRESC+1 cycles; PRESC=0 toggles every cycle.
  - Any write to PRESC forces presc_cnt<=0 and blink_phase<=0 at that edge.
- PWM:
  - pwm_cnt is free-running and wraps 2^PWM_BITS-1 -> 0.
  - pwm_on[i] = (pwm_cnt < DUTY[i]).
  - DUTY=0 gives always off; DUTY=2^PWM_BITS-1 gives on for 255 of 256 cycles (PWM_BITS=8).
- Channel output (registered), led[i] <= f(MODE[i]):
  - 00 direct: DATA[i].
  - 01 blink: DATA[i] & blink_phase.
  - 10 PWM: DATA[i] & pwm_on[i].
  - 11 blinking PWM: DATA[i] & pwm_on[i] & blink_phase.
- Register updates take effect on the next PWM/blink evaluation; there is no period-boundary synchronisation.

Decomposition:
- Package mmio_led_pkg holds:
  - address constants: ADDR_DATA=0, ADDR_MODE=1, ADDR_PRESC=2, ADDR_STATUS=3, ADDR_DUTY_BASE=4;
  - mode encodings: MODE_DIRECT=2'b00, MODE_BLINK=2'b01, MODE_PWM=2'b10, MODE_BLINK_PWM=2'b11.
- One sub-module, mmio_led_channel:
  - inputs: DATA bit, mode, duty, pwm_cnt, blink_phase;
  - contains the registered led bit and its synchronous reset;
  - instantiated NUM_CH times in a generate loop.
- Shared prescaler, PWM counter and register file stay in the top.

Test Plan:
- Reset: hold rst=1 for 2 cycles with we=1, addr=0, wdata=FF -> led=00, rdata=0, rvalid=0. Read PRESC after release -> BLINK_DEFAULT.
- Direct mode: write DATA=A5 at edge k -> led=A5 at edge k+1. Read addr 0 -> rdata=A5, rvalid pulse of exactly 1 cycle.
- Blink: MODE=0x0001, PRESC=3, DATA=01 -> led[0] is 0 for 4 cycles, then 1 for 4 cycles, repeating. Rewriting PRESC mid-phase restarts with phase 0.
- PWM boundaries: MODE[1:0]=10, DATA=01:
  - DUTY0=0 -> led[0] never high over 512 cycles;
  - DUTY0=64 -> exactly 64 high per 256;
  - DUTY0=255 -> exactly 255 high per 256.
- Access edge cases:
  - same-cycle we/re to DATA (old 0F, new F0) -> rdata=0F, then DATA reads F0;
  - write STATUS or addr 31 -> no register change, reads of addr 31 return 0.
- Blinking PWM: MODE[1:0]=11, PRESC=255, DUTY0=128 -> led[0] high 128/256 cycles during phase 1, 0 throughout phase 0.
